cp0_reg: RTL and testbench

CP0_REG -- requirements
Module: cp0_reg

---
 rtl/cp0_reg.sv | 235 +++++++++++++++++++++++
 tb/tb_cp0_reg.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg.sv
// cp0_reg: MIPS coprocessor-0 register file (Status, Cause, EPC, EBase, Count,
// Compare, BadVAddr) with commit-stage exception/ERET handling and a
// Count/Compare timer.
//
// Build option: define CP0_TIMER_EN to include the Count/Compare timer. When
// undefined, Count/Compare read 0, ignore writes, and timer_int_o is 0.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   wen, waddr, wdata    MTC0 write (commit stage)
//   raddr, rdata         MFC0 read, combinational, 0 for unmapped numbers
//   int_i                hardware interrupt lines HW5..HW0
//   exception_type_i     exception code from the memory stage
//   pc_i, is_in_delayslot_i, bad_addr_i   exception context
//   *_o                  register contents; timer_int_o timer interrupt
module cp0_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  int_i,
  input  logic [31:0] exception_type_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] ebase_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0] AddrBadVAddr = 5'd8;
  localparam logic [4:0] AddrCount    = 5'd9;
  localparam logic [4:0] AddrCompare  = 5'd11;
  localparam logic [4:0] AddrStatus   = 5'd12;
  localparam logic [4:0] AddrCause    = 5'd13;
  localparam logic [4:0] AddrEpc      = 5'd14;
  localparam logic [4:0] AddrEBase    = 5'd15;

  localparam logic [31:0] ExcInt  = 32'h1;
  localparam logic [31:0] ExcAdel = 32'h4;
  localparam logic [31:0] ExcAdes = 32'h5;
  localparam logic [31:0] ExcSys  = 32'h8;
  localparam logic [31:0] ExcBrk  = 32'h9;
  localparam logic [31:0] ExcRi   = 32'hA;
  localparam logic [31:0] ExcOv   = 32'hC;
  localparam logic [31:0] ExcEret = 32'hE;

  // Only the writable/architecturally live fields are stored.
  logic [7:0]  status_im_q, status_im_d;
  logic        status_exl_q, status_exl_d;
  logic        status_ie_q, status_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic        cause_iv_q, cause_iv_d;
  logic [5:0]  cause_hw_q, cause_hw_d;
  logic [1:0]  cause_sw_q, cause_sw_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ebase_q, ebase_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        timer_int;
  logic        exc_valid;
  logic        exc_eret;
  logic [4:0]  exc_code;
  logic        exl_after_wr;

  always_comb begin
    exc_valid = 1'b0;
    exc_eret  = 1'b0;
    exc_code  = 5'd0;
    case (exception_type_i)
      ExcInt: exc_valid = 1'b1;
      ExcAdel, ExcAdes, ExcSys, ExcBrk, ExcRi, ExcOv: begin
        exc_valid = 1'b1;
        exc_code  = exception_type_i[4:0];
      end
      ExcEret: exc_eret = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    status_im_d  = status_im_q;
    status_exl_d = status_exl_q;
    status_ie_d  = status_ie_q;
    cause_bd_d   = cause_bd_q;
    cause_iv_d   = cause_iv_q;
    cause_sw_d   = cause_sw_q;
    cause_exc_d  = cause_exc_q;
    epc_d        = epc_q;
    ebase_d      = ebase_q;
    badvaddr_d   = badvaddr_q;
    cause_hw_d   = {int_i[5] | timer_int, int_i[4:0]};

    // MTC0 first; exception handling below overrides overlapping fields.
    if (wen) begin
      case (waddr)
        AddrStatus: begin
          status_im_d  = wdata[15:8];
          status_exl_d = wdata[1];
          status_ie_d  = wdata[0];
        end
        AddrCause: begin
          cause_iv_d = wdata[23];
          cause_sw_d = wdata[9:8];
        end
        AddrEpc:   epc_d   = wdata;
        AddrEBase: ebase_d = wdata;
        default: ;
      endcase
    end

    exl_after_wr = status_exl_d;

    if (exc_eret) begin
      status_exl_d = 1'b0;
    end else if (exc_valid) begin
      // Nested exceptions (EXL already set) keep the original EPC/BD.
      if (!exl_after_wr) begin
        epc_d        = is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        cause_bd_d   = is_in_delayslot_i;
        status_exl_d = 1'b1;
      end
      cause_exc_d = exc_code;
      if (exception_type_i == ExcAdel || exception_type_i == ExcAdes) begin
        badvaddr_d = bad_addr_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_im_q  <= 8'd0;
      status_exl_q <= 1'b0;
      status_ie_q  <= 1'b0;
      cause_bd_q   <= 1'b0;
      cause_iv_q   <= 1'b0;
      cause_hw_q   <= 6'd0;
      cause_sw_q   <= 2'd0;
      cause_exc_q  <= 5'd0;
      epc_q        <= 32'd0;
      ebase_q      <= 32'h8000_0000;
      badvaddr_q   <= 32'd0;
    end else begin
      status_im_q  <= status_im_d;
      status_exl_q <= status_exl_d;
      status_ie_q  <= status_ie_d;
      cause_bd_q   <= cause_bd_d;
      cause_iv_q   <= cause_iv_d;
      cause_hw_q   <= cause_hw_d;
      cause_sw_q   <= cause_sw_d;
      cause_exc_q  <= cause_exc_d;
      epc_q        <= epc_d;
      ebase_q      <= ebase_d;
      badvaddr_q   <= badvaddr_d;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        toggle_q, toggle_d;
  logic        timer_q, timer_d;

  always_comb begin
    toggle_d  = ~toggle_q;
    count_d   = toggle_q ? (count_q + 32'd1) : count_q;
    compare_d = compare_q;
    timer_d   = timer_q | ((count_q == compare_q) && (compare_q != 32'd0));
    if (wen && waddr == AddrCount) begin
      count_d  = wdata;
      toggle_d = 1'b0;
    end
    // A Compare write clears the interrupt even on a coincident match.
    if (wen && waddr == AddrCompare) begin
      compare_d = wdata;
      timer_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      toggle_q  <= 1'b0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      toggle_q  <= toggle_d;
      timer_q   <= timer_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign timer_int = timer_q;
`else
  assign count_o   = 32'd0;
  assign compare_o = 32'd0;
  assign timer_int = 1'b0;
`endif

  assign timer_int_o = timer_int;

  assign status_o   = {9'd0, 1'b1, 6'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
  assign cause_o    = {cause_bd_q, 7'd0, cause_iv_q, 7'd0, cause_hw_q, cause_sw_q, 1'b0,
                       cause_exc_q, 2'd0};
  assign epc_o      = epc_q;
  assign ebase_o    = ebase_q;
  assign badvaddr_o = badvaddr_q;

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      AddrBadVAddr: rdata = badvaddr_o;
      AddrCount:    rdata = count_o;
      AddrCompare:  rdata = compare_o;
      AddrStatus:   rdata = status_o;
      AddrCause:    rdata = cause_o;
      AddrEpc:      rdata = epc_o;
      AddrEBase:    rdata = ebase_o;
      default:      rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg. Expected values are pushed to a scoreboard
// queue as stimulus is driven and popped when the DUT state is sampled
// (1 time unit after the rising edge). Timer expectations follow the
// CP0_TIMER_EN build option.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  int_i;
  logic [31:0] exception_type_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] status_o, cause_o, epc_o, ebase_o, count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cp0_reg dut (
    .clk               (clk),
    .reset             (reset),
    .wen               (wen),
    .waddr             (waddr),
    .wdata             (wdata),
    .raddr             (raddr),
    .rdata             (rdata),
    .int_i             (int_i),
    .exception_type_i  (exception_type_i),
    .pc_i              (pc_i),
    .is_in_delayslot_i (is_in_delayslot_i),
    .bad_addr_i        (bad_addr_i),
    .status_o          (status_o),
    .cause_o           (cause_o),
    .epc_o             (epc_o),
    .ebase_o           (ebase_o),
    .count_o           (count_o),
    .compare_o         (compare_o),
    .badvaddr_o        (badvaddr_o),
    .timer_int_o       (timer_int_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; waddr = 5'd0; wdata = 32'd0; raddr = 5'd0; int_i = 6'd0;
    exception_type_i = 32'd0; pc_i = 32'd0; is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
  endtask

  // Both reset checks compare all registers against the reset image.
  task automatic test_reset();
    logic [31:0] obs[8];
    exp_t e;
    idle();
    reset = 1'b1;
    #3;
    sb.push_back('{"rst_status", 32'h0040_0000});
    sb.push_back('{"rst_cause", 32'h0});
    sb.push_back('{"rst_epc", 32'h0});
    sb.push_back('{"rst_ebase", 32'h8000_0000});
    sb.push_back('{"rst_count", 32'h0});
    sb.push_back('{"rst_compare", 32'h0});
    sb.push_back('{"rst_badvaddr", 32'h0});
    sb.push_back('{"rst_timer", 32'h0});
    obs = '{status_o, cause_o, epc_o, ebase_o, count_o, compare_o, badvaddr_o,
            {31'd0, timer_int_o}};
    for (int i = 0; i < 8; i++) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs[i] !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h, expected %h", e.name, obs[i], e.exp);
      end
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_status();
    exp_t e;
    do_reset();
    mtc0(5'd12, 32'h0000_FF01);
    sb.push_back('{"status_ff01", 32'h0040_FF01});
    tick();
    e = sb.pop_front(); n_cmp++;
    if (status_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, status_o, e.exp);
    end
    mtc0(5'd12, 32'hFFFF_FFFF);
    sb.push_back('{"status_all1", 32'h0040_FF03});
    tick();
    wen = 1'b0; raddr = 5'd12;
    e = sb.pop_front(); n_cmp++;
    if (status_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, status_o, e.exp);
    end
    sb.push_back('{"rdata_status", 32'h0040_FF03});
    #1;
    e = sb.pop_front(); n_cmp++;
    if (rdata !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, rdata, e.exp);
    end
  endtask

  task automatic test_exc_sys();
    exp_t e;
    do_reset();
    exception_type_i = 32'h8; pc_i = 32'hBFC0_0100; is_in_delayslot_i = 1'b0;
    sb.push_back('{"sys1_epc", 32'hBFC0_0100});
    sb.push_back('{"sys1_cause", 32'h0000_0020});
    sb.push_back('{"sys1_status", 32'h0040_0002});
    tick();
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front(); n_cmp++;
      if (epc_o !== e.exp) begin
        n_err++; $display("FAIL %s: got %h, expected %h", e.name, epc_o, e.exp);
      end
      e = sb.pop_front(); n_cmp++;
      if (cause_o !== e.exp) begin
        n_err++; $display("FAIL %s: got %h, expected %h", e.name, cause_o, e.exp);
      end
      e = sb.pop_front(); n_cmp++;
      if (status_o !== e.exp) begin
        n_err++; $display("FAIL %s: got %h, expected %h", e.name, status_o, e.exp);
      end
      if (k == 0) begin
        // Second SYS with EXL already set leaves EPC/BD/EXL alone.
        pc_i = 32'hBFC0_0200;
        sb.push_back('{"sys2_epc", 32'hBFC0_0100});
        sb.push_back('{"sys2_cause", 32'h0000_0020});
        sb.push_back('{"sys2_status", 32'h0040_0002});
        tick();
      end
    end
    idle();
  endtask

  task automatic test_exc_adel();
    exp_t e;
    do_reset();
    exception_type_i = 32'h4; pc_i = 32'hBFC0_0104; is_in_delayslot_i = 1'b1;
    bad_addr_i = 32'h0000_0003;
    sb.push_back('{"adel_epc", 32'hBFC0_0100});
    sb.push_back('{"adel_cause", 32'h8000_0010});
    sb.push_back('{"adel_badvaddr", 32'h0000_0003});
    tick();
    idle();
    e = sb.pop_front(); n_cmp++;
    if (epc_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, epc_o, e.exp);
    end
    e = sb.pop_front(); n_cmp++;
    if (cause_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, cause_o, e.exp);
    end
    e = sb.pop_front(); n_cmp++;
    if (badvaddr_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, badvaddr_o, e.exp);
    end
  endtask

  task automatic test_write_exc_overlap();
    exp_t e;
    do_reset();
    mtc0(5'd14, 32'h1234_5678);
    exception_type_i = 32'hC; pc_i = 32'hBFC0_0010;
    sb.push_back('{"ov_epc", 32'hBFC0_0010});
    sb.push_back('{"ov_status", 32'h0040_0002});
    tick();
    wen = 1'b0;
    exception_type_i = 32'hE;
    e = sb.pop_front(); n_cmp++;
    if (epc_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, epc_o, e.exp);
    end
    e = sb.pop_front(); n_cmp++;
    if (status_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, status_o, e.exp);
    end
    sb.push_back('{"eret_status", 32'h0040_0000});
    sb.push_back('{"eret_epc", 32'hBFC0_0010});
    sb.push_back('{"eret_cause", 32'h0000_0030});
    tick();
    idle();
    e = sb.pop_front(); n_cmp++;
    if (status_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, status_o, e.exp);
    end
    e = sb.pop_front(); n_cmp++;
    if (epc_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, epc_o, e.exp);
    end
    e = sb.pop_front(); n_cmp++;
    if (cause_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, cause_o, e.exp);
    end
  endtask

  task automatic test_misc_regs();
    exp_t e;
    do_reset();
    mtc0(5'd13, 32'hFFFF_FFFF);
    int_i = 6'b101010;
    sb.push_back('{"cause_wr_int", 32'h0080_AB00});
    tick();
    e = sb.pop_front(); n_cmp++;
    if (cause_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, cause_o, e.exp);
    end
    int_i = 6'd0;
    mtc0(5'd8, 32'hDEAD_BEEF);
    exception_type_i = 32'h3;  // unlisted code: no exception
    sb.push_back('{"badvaddr_ro", 32'h0});
    sb.push_back('{"unknown_exc_cause", 32'h0080_0300});
    tick();
    exception_type_i = 32'h0;
    e = sb.pop_front(); n_cmp++;
    if (badvaddr_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, badvaddr_o, e.exp);
    end
    e = sb.pop_front(); n_cmp++;
    if (cause_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, cause_o, e.exp);
    end
    mtc0(5'd15, 32'h1234_5000);
    sb.push_back('{"ebase_rd", 32'h1234_5000});
    tick();
    wen = 1'b0; raddr = 5'd15;
    #1;
    e = sb.pop_front(); n_cmp++;
    if (rdata !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, rdata, e.exp);
    end
    raddr = 5'd3;
    sb.push_back('{"unmapped_rd", 32'h0});
    #1;
    e = sb.pop_front(); n_cmp++;
    if (rdata !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, rdata, e.exp);
    end
    idle();
  endtask

  task automatic test_timer();
    exp_t e;
    do_reset();
    mtc0(5'd11, 32'd5);
    tick();
    mtc0(5'd9, 32'd0);
    tick();
    wen = 1'b0;
`ifdef CP0_TIMER_EN
    sb.push_back('{"cnt_load", 32'd0});
    e = sb.pop_front(); n_cmp++;
    if (count_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, count_o, e.exp);
    end
    repeat (9) tick();
    sb.push_back('{"cnt_at10", 32'd5});
    sb.push_back('{"tmr_before", 32'd0});
    tick();
    e = sb.pop_front(); n_cmp++;
    if (count_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, count_o, e.exp);
    end
    e = sb.pop_front(); n_cmp++;
    if ({31'd0, timer_int_o} !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, timer_int_o, e.exp);
    end
    sb.push_back('{"tmr_set", 32'd1});
    tick();
    e = sb.pop_front(); n_cmp++;
    if ({31'd0, timer_int_o} !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, timer_int_o, e.exp);
    end
    sb.push_back('{"cause_ip7", 32'h0000_8000});
    tick();
    e = sb.pop_front(); n_cmp++;
    if (cause_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, cause_o, e.exp);
    end
    mtc0(5'd11, 32'h20);
    sb.push_back('{"tmr_clr", 32'd0});
    tick();
    e = sb.pop_front(); n_cmp++;
    if ({31'd0, timer_int_o} !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, timer_int_o, e.exp);
    end
    mtc0(5'd9, 32'h1F);
    tick();
    wen = 1'b0;
    tick();
    tick();
    sb.push_back('{"tmr_match20", 32'd1});
    tick();
    e = sb.pop_front(); n_cmp++;
    if ({31'd0, timer_int_o} !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, timer_int_o, e.exp);
    end
    // Compare write on a cycle where Count still equals Compare: clear wins.
    mtc0(5'd11, 32'h20);
    sb.push_back('{"tmr_clr_wins", 32'd0});
    sb.push_back('{"tmr_stays_clr", 32'd0});
    tick();
    wen = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if ({31'd0, timer_int_o} !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, timer_int_o, e.exp);
    end
    tick();
    e = sb.pop_front(); n_cmp++;
    if ({31'd0, timer_int_o} !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, timer_int_o, e.exp);
    end
    mtc0(5'd9, 32'hFFFF_FFFF);
    tick();
    wen = 1'b0;
    sb.push_back('{"cnt_wrap", 32'd0});
    tick();
    tick();
    e = sb.pop_front(); n_cmp++;
    if (count_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, count_o, e.exp);
    end
`else
    sb.push_back('{"cnt_off", 32'd0});
    sb.push_back('{"cmp_off", 32'd0});
    sb.push_back('{"tmr_off", 32'd0});
    repeat (12) tick();
    e = sb.pop_front(); n_cmp++;
    if (count_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, count_o, e.exp);
    end
    e = sb.pop_front(); n_cmp++;
    if (compare_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, compare_o, e.exp);
    end
    e = sb.pop_front(); n_cmp++;
    if ({31'd0, timer_int_o} !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, timer_int_o, e.exp);
    end
    int_i = 6'b100000;
    sb.push_back('{"cause_hw5", 32'h0000_8000});
    tick();
    e = sb.pop_front(); n_cmp++;
    if (cause_o !== e.exp) begin
      n_err++; $display("FAIL %s: got %h, expected %h", e.name, cause_o, e.exp);
    end
`endif
    idle();
  endtask

  task automatic test_async_reset();
    logic [31:0] obs[8];
    exp_t e;
    do_reset();
    mtc0(5'd12, 32'h0000_FF01); tick();
    mtc0(5'd14, 32'hCAFE_0000); tick();
    mtc0(5'd15, 32'h0000_1000); tick();
    mtc0(5'd11, 32'h0000_0040); tick();
    // Pending write and exception at reset time must be discarded.
    mtc0(5'd14, 32'h1111_1111);
    exception_type_i = 32'h4; bad_addr_i = 32'h55; pc_i = 32'h100;
    #2;
    reset = 1'b1;
    #1;
    sb.push_back('{"arst_status", 32'h0040_0000});
    sb.push_back('{"arst_cause", 32'h0});
    sb.push_back('{"arst_epc", 32'h0});
    sb.push_back('{"arst_ebase", 32'h8000_0000});
    sb.push_back('{"arst_count", 32'h0});
    sb.push_back('{"arst_compare", 32'h0});
    sb.push_back('{"arst_badvaddr", 32'h0});
    sb.push_back('{"arst_timer", 32'h0});
    obs = '{status_o, cause_o, epc_o, ebase_o, count_o, compare_o, badvaddr_o,
            {31'd0, timer_int_o}};
    for (int i = 0; i < 8; i++) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs[i] !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h, expected %h", e.name, obs[i], e.exp);
      end
    end
    idle();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_status();
    test_exc_sys();
    test_exc_adel();
    test_write_exc_overlap();
    test_misc_regs();
    test_timer();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
